// File: rtl/program_store_pkg.sv
// Shared definitions for the program store: state encoding, fill byte, fetch latency.
package program_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] FILL_BYTE_DEF = 8'h00;
  localparam int         FETCH_LAT     = 1;

endpackage

// File: rtl/program_store_prog_mem.sv
// Program byte storage: one synchronous write port, one synchronous read port.
module program_store_prog_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_store.sv
// Instruction-memory responder: byte-stream loader, fetch responder and EOI counter
// in front of the on-chip program storage.
module program_store
  import program_store_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic [15:0]       program_addr,
  input  logic              rom_cs,
  input  logic              rom_rd,
  input  logic              eoi,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W:0]   loaded_len,
  output logic [15:0]       instr_count,
  output logic              fetch_err,
  output logic [1:0]        state
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              load_ready_q, load_ready_d;
  logic              pend_q, pend_d;
  logic              pend_in_range_q, pend_in_range_d;
  logic [7:0]        instruction_q, instruction_d;
  logic              instr_valid_q, instr_valid_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              fetch_err_q, fetch_err_d;

  logic              fetch;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  program_store_prog_mem #(
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (program_addr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    instr_count_d   = instr_count_q;
    fetch_err_d     = fetch_err_q;
    instruction_d   = instruction_q;
    instr_valid_d   = 1'b0;
    mem_we          = 1'b0;

    // Full 16-bit compare so any non-zero upper address bit lands out of range.
    fetch    = rom_cs & rom_rd;
    in_range = program_addr < 16'(wr_ptr_q);

    // Fetch sample stage: read issued to storage, range decision carried along.
    mem_re          = fetch && (state_q == ST_RUN);
    pend_d          = mem_re;
    pend_in_range_d = in_range;
    if (fetch && ((state_q != ST_RUN) || !in_range)) fetch_err_d = 1'b1;

    // Response stage: storage data (or fill) presented with a one-cycle valid.
    if (pend_q) begin
      instruction_d = pend_in_range_q ? mem_rdata : FILL_BYTE;
      instr_valid_d = 1'b1;
    end

    // load_start has priority over everything, including a same-cycle load_done.
    if (load_start) begin
      state_d       = ST_LOAD;
      wr_ptr_d      = '0;
      instr_count_d = '0;
      fetch_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_valid && load_ready_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
          end
          if (load_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (eoi && (instr_count_q != 16'hFFFF)) instr_count_d = instr_count_q + 16'd1;
        end
        default: ;
      endcase
    end

    load_ready_d = (state_d == ST_LOAD) && (wr_ptr_d < DEPTH_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      load_ready_q  <= 1'b0;
      pend_q        <= 1'b0;
      instruction_q <= 8'h00;
      instr_valid_q <= 1'b0;
      instr_count_q <= 16'h0000;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_ready_q  <= load_ready_d;
      pend_q        <= pend_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      instr_count_q <= instr_count_d;
      fetch_err_q   <= fetch_err_d;
    end
    pend_in_range_q <= pend_in_range_d;
  end

  assign load_ready  = load_ready_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign loaded_len  = wr_ptr_q;
  assign instr_count = instr_count_q;
  assign fetch_err   = fetch_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_program_store.sv
// Randomised and directed bench for program_store against a behavioural model.
module tb_program_store;

  localparam int         ADDR_W = 8;
  localparam int         DEPTH  = 256;
  localparam logic [7:0] FILL   = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start, load_done, load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [15:0] program_addr;
  logic        rom_cs, rom_rd, eoi;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic [8:0]  loaded_len;
  logic [15:0] instr_count;
  logic        fetch_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  program_store #(.ADDR_W(ADDR_W), .FILL_BYTE(FILL)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_done    (load_done),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .program_addr (program_addr),
    .rom_cs       (rom_cs),
    .rom_rd       (rom_rd),
    .eoi          (eoi),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .loaded_len   (loaded_len),
    .instr_count  (instr_count),
    .fetch_err    (fetch_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: state name, program image, length, counters, one outstanding response.
  int         m_state;
  int         m_len;
  logic [7:0] m_mem [DEPTH];
  int         m_count;
  bit         m_err;
  bit         m_iv;
  logic [7:0] m_instr;
  bit         m_pend;
  logic [7:0] m_pend_val;
  bit         started = 0;

  always @(posedge clk) begin
    bit         np;
    logic [7:0] nv;
    if (reset) begin
      started = 1;
      m_state = 0; m_len = 0; m_count = 0; m_err = 0;
      m_iv = 0; m_instr = 8'h00; m_pend = 0;
    end else begin
      np = 0; nv = FILL;
      if (rom_cs && rom_rd) begin
        if (m_state == 2) begin
          np = 1;
          if (int'(program_addr) < m_len) nv = m_mem[program_addr[7:0]];
          else m_err = 1;
        end else m_err = 1;
      end
      m_iv = m_pend;
      if (m_pend) m_instr = m_pend_val;
      m_pend = np; m_pend_val = nv;
      if (load_start) begin
        m_state = 1; m_len = 0; m_count = 0; m_err = 0;
      end else if (m_state == 1) begin
        if (load_valid && m_len < DEPTH) begin
          m_mem[m_len] = load_data;
          m_len++;
        end
        if (load_done) m_state = 2;
      end else if (m_state == 2 && eoi && m_count < 65535) begin
        m_count++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("state", 32'(state), 32'(m_state));
      check("load_ready", 32'(load_ready), 32'(m_state == 1 && m_len < DEPTH));
      check("loaded_len", 32'(loaded_len), 32'(m_len));
      check("instr_count", 32'(instr_count), 32'(m_count));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
      check("instr_valid", 32'(instr_valid), 32'(m_iv));
      check("instruction", 32'(instruction), 32'(m_instr));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_start = 0; load_done = 0; load_valid = 0; load_data = 8'h00;
    rom_cs = 0; rom_rd = 0; eoi = 0; program_addr = 16'h0000;
  endtask

  task automatic fetch_once(input logic [15:0] a);
    rom_cs = 1; rom_rd = 1; program_addr = a;
    tick();
    idle();
    tick();
  endtask

  logic [7:0] img [DEPTH + 2];
  logic [7:0] seq4 [4];

  initial begin
    seq4[0] = 8'hA1; seq4[1] = 8'hB2; seq4[2] = 8'hC3; seq4[3] = 8'hD4;
    reset = 1;
    idle();
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_len", 32'(loaded_len), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    reset = 0;

    // Load four bytes, last one together with load_done.
    load_start = 1; tick(); load_start = 0;
    check("ready_after_start", 32'(load_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = seq4[i]; load_done = (i == 3);
      tick();
    end
    idle();
    check("lit_len4", 32'(loaded_len), 32'd4);
    check("lit_run", 32'(state), 32'd2);

    rom_cs = 1; rom_rd = 1; program_addr = 16'd2;
    tick(); idle();
    check("lit_no_valid_yet", 32'(instr_valid), 32'd0);
    tick();
    check("lit_fetch2", 32'(instruction), 32'hC3);
    check("lit_fetch2_valid", 32'(instr_valid), 32'd1);
    tick();
    check("lit_valid_pulse", 32'(instr_valid), 32'd0);
    check("lit_hold", 32'(instruction), 32'hC3);

    fetch_once(16'd5);
    check("lit_oor_fill", 32'(instruction), 32'h00);
    check("lit_oor_err", 32'(fetch_err), 32'd1);
    fetch_once(16'd0);
    check("lit_fetch0", 32'(instruction), 32'hA1);
    fetch_once(16'h0100);
    check("lit_upper_fill", 32'(instruction), 32'h00);

    eoi = 1; tick(); tick(); tick(); eoi = 0;
    check("lit_eoi3", 32'(instr_count), 32'd3);

    // Abort the run with both control pulses together.
    load_start = 1; load_done = 1; tick(); idle();
    check("lit_abort_state", 32'(state), 32'd1);
    check("lit_abort_count", 32'(instr_count), 32'd0);
    check("lit_abort_err", 32'(fetch_err), 32'd0);
    eoi = 1; tick(); tick(); eoi = 0;
    check("lit_eoi_load", 32'(instr_count), 32'd0);

    // Fill storage completely, then keep offering bytes.
    for (int i = 0; i < DEPTH + 2; i++) begin
      img[i] = 8'($urandom);
      load_valid = 1; load_data = img[i];
      tick();
      if (i == DEPTH - 1) begin
        check("lit_full_ready", 32'(load_ready), 32'd0);
        check("lit_full_len", 32'(loaded_len), 32'd256);
      end
    end
    idle();
    check("lit_len256", 32'(loaded_len), 32'd256);
    load_done = 1; tick(); idle();
    fetch_once(16'd0);
    check("lit_nowrap", 32'(instruction), 32'(img[0]));
    fetch_once(16'd255);
    check("lit_last", 32'(instruction), 32'(img[255]));

    // Reset during back-to-back fetches.
    rom_cs = 1; rom_rd = 1; program_addr = 16'd1;
    tick(); tick();
    reset = 1; tick(); reset = 0; idle();
    check("lit_rst_valid", 32'(instr_valid), 32'd0);
    check("lit_rst_state", 32'(state), 32'd0);
    check("lit_rst_instr", 32'(instruction), 32'd0);
    tick();
    check("lit_rst_discard", 32'(instr_valid), 32'd0);
    rom_cs = 1; rom_rd = 1; program_addr = 16'd0;
    tick(); idle();
    check("lit_idle_err", 32'(fetch_err), 32'd1);
    tick();
    check("lit_idle_novalid", 32'(instr_valid), 32'd0);
    reset = 1; tick(); reset = 0;

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      case (m_state)
        0: load_start = 1;
        1: begin
          load_valid = ($urandom % 4) != 0;
          load_data  = 8'($urandom);
          load_done  = ($urandom % 24) == 0;
          eoi        = ($urandom % 3) == 0;
          if (($urandom % 16) == 0) begin
            rom_cs = 1; rom_rd = 1; program_addr = 16'($urandom_range(0, 300));
          end
        end
        default: begin
          if (($urandom % 150) == 0) begin
            load_start = 1; load_done = 1'($urandom % 2);
          end else begin
            rom_cs = ($urandom % 4) != 0;
            rom_rd = ($urandom % 4) != 0;
            program_addr = (($urandom % 16) == 0) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 300));
            eoi = ($urandom % 2) == 0;
          end
        end
      endcase
      tick();
    end
    idle();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
